// File: rtl/period_meter_5bit_if.sv
// Bus bundle for the period meter: control and stimulus inputs from the
// loop side, measurement results back out. The meter uses the slave view.
interface period_meter_5bit_if #(
    parameter int WIDTH = 5
);
    logic             enable;
    logic             sig_in;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] period_out;
    logic             period_valid;
    logic             overflow;
    logic [WIDTH-1:0] freq_err;
    logic             freq_err_sign;
    logic             locked;

    modport master (
        output enable,
        output sig_in,
        output expected,
        input  period_out,
        input  period_valid,
        input  overflow,
        input  freq_err,
        input  freq_err_sign,
        input  locked
    );

    modport slave (
        input  enable,
        input  sig_in,
        input  expected,
        output period_out,
        output period_valid,
        output overflow,
        output freq_err,
        output freq_err_sign,
        output locked
    );
endinterface

// File: rtl/period_meter_5bit.sv
// Period meter: counts clk cycles between rising edges of a slow, asynchronous
// loop clock, compares the result with an expected period and maintains a
// lock indicator from a streak of in-tolerance measurements.
module period_meter_5bit #(
    parameter int WIDTH       = 5,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_TOL    = 1,
    parameter int LOCK_COUNT  = 4
) (
    input  logic               clk,
    input  logic               reset,
    period_meter_5bit_if.slave bus
);

    localparam int STREAK_W = $clog2(LOCK_COUNT + 1);

    localparam logic [WIDTH-1:0]    CNT_MAX     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]    CNT_ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]    CNT_ONE     = WIDTH'(1);
    localparam logic [STREAK_W-1:0] STREAK_ZERO = {STREAK_W{1'b0}};
    localparam logic [STREAK_W-1:0] STREAK_ONE  = STREAK_W'(1);
    localparam logic [STREAK_W-1:0] STREAK_FULL = STREAK_W'(LOCK_COUNT);
    localparam logic [WIDTH:0]      TOL         = (WIDTH + 1)'(LOCK_TOL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_MEAS = 2'd2
    } state_t;

    // Magnitude of a - b, evaluated one bit wider so neither order can wrap.
    function automatic logic [WIDTH:0] abs_diff(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH:0] ea;
        logic [WIDTH:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        if (ea > eb) begin
            abs_diff = ea - eb;
        end else begin
            abs_diff = eb - ea;
        end
    endfunction

    // Synchronizer and edge detect
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_edge;

    // Measurement state
    state_t                 r_state;
    logic [WIDTH-1:0]       r_count;
    logic                   r_sat;

    // Registered results
    logic [WIDTH-1:0]       r_period;
    logic [WIDTH-1:0]       r_err;
    logic                   r_sign;
    logic                   r_ovf;
    logic                   r_valid;
    logic                   r_locked;
    logic [STREAK_W-1:0]    r_streak;

    // Capture-time arithmetic
    logic [WIDTH:0]         w_abs;
    logic                   w_gt;
    logic                   w_in_tol;
    logic [STREAK_W-1:0]    w_streak_next;
    logic                   w_lock_next;

    // Bring sig_in into the clk domain and remember the last synced level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= {SYNC_STAGES{1'b0}};
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.sig_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

    // Error magnitude, direction and the lock streak a capture this cycle would produce.
    always_comb begin
        w_abs         = abs_diff(r_count, bus.expected);
        w_gt          = (r_count > bus.expected);
        w_in_tol      = 1'b0;
        w_streak_next = STREAK_ZERO;
        w_lock_next   = 1'b0;

        // A saturated capture is never in tolerance, whatever the error.
        if (!r_sat && (w_abs <= TOL)) begin
            w_in_tol = 1'b1;
        end else begin
            w_in_tol = 1'b0;
        end

        if (!w_in_tol) begin
            w_streak_next = STREAK_ZERO;
        end else if (r_streak >= STREAK_FULL) begin
            w_streak_next = STREAK_FULL;
        end else begin
            w_streak_next = r_streak + STREAK_ONE;
        end

        if (w_streak_next == STREAK_FULL) begin
            w_lock_next = 1'b1;
        end else begin
            w_lock_next = 1'b0;
        end
    end

    // Measurement FSM: arm on the first edge, count clk cycles between edges,
    // capture results and update the lock streak on every later edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_count  <= CNT_ZERO;
            r_sat    <= 1'b0;
            r_period <= CNT_ZERO;
            r_err    <= CNT_ZERO;
            r_sign   <= 1'b0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
            r_streak <= STREAK_ZERO;
        end else begin
            r_valid <= 1'b0;
            // Disable wins over a coincident edge; captured results are kept.
            if (!bus.enable) begin
                r_state  <= S_IDLE;
                r_count  <= CNT_ZERO;
                r_sat    <= 1'b0;
                r_streak <= STREAK_ZERO;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_count <= CNT_ZERO;
                        r_sat   <= 1'b0;
                        r_state <= S_ARM;
                    end
                    S_ARM: begin
                        if (w_edge) begin
                            r_count <= CNT_ONE;
                            r_sat   <= 1'b0;
                            r_state <= S_MEAS;
                        end else begin
                            r_count <= CNT_ZERO;
                        end
                    end
                    S_MEAS: begin
                        if (w_edge) begin
                            r_period <= r_count;
                            r_ovf    <= r_sat;
                            r_err    <= w_abs[WIDTH-1:0];
                            r_sign   <= w_gt;
                            r_valid  <= 1'b1;
                            r_streak <= w_streak_next;
                            r_locked <= w_lock_next;
                            r_count  <= CNT_ONE;
                            r_sat    <= 1'b0;
                        end else if (r_count == CNT_MAX) begin
                            // Counting past full scale: hold at max and remember it.
                            r_sat <= 1'b1;
                        end else begin
                            r_count <= r_count + CNT_ONE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_count <= CNT_ZERO;
                        r_sat   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.period_out    = r_period;
    assign bus.period_valid  = r_valid;
    assign bus.overflow      = r_ovf;
    assign bus.freq_err      = r_err;
    assign bus.freq_err_sign = r_sign;
    assign bus.locked        = r_locked;

endmodule

// File: tb/tb_period_meter_5bit.sv
// Bench for period_meter_5bit: drives square waves of chosen periods and
// compares every cycle's outputs with a model that works from the cycle
// numbers at which sig_in rises.
module tb_period_meter_5bit;

    localparam int WIDTH      = 5;
    localparam int MAXV       = 31;
    localparam int LOCK_TOL   = 1;
    localparam int LOCK_COUNT = 4;

    logic clk;
    logic reset;

    period_meter_5bit_if #(.WIDTH(WIDTH)) pm_if ();

    period_meter_5bit #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2),
        .LOCK_TOL    (LOCK_TOL),
        .LOCK_COUNT  (LOCK_COUNT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (pm_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // square-wave generator
    int cur_p  = 8;
    int next_p = 8;
    int phase  = 0;

    // reference model state
    int pend[$];          // posedge numbers at which a sampled rise reaches the meter
    int cyc       = 0;
    bit sig_prev  = 1'b0;
    bit en_ok     = 1'b0; // enabled long enough to be past the idle cycle
    bit have_prev = 1'b0; // a previous edge time exists since arming
    int prev_p    = 0;
    int streak    = 0;
    int m_period  = 0;
    int m_err     = 0;
    bit m_sign    = 1'b0;
    bit m_ovf     = 1'b0;
    bit m_valid   = 1'b0;
    bit m_locked  = 1'b0;

    int nvalid   = 0;
    bit lock_at3 = 1'b0;
    bit lock_at4 = 1'b0;

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic check_all();
        check_val("valid",    pm_if.period_valid,  m_valid);
        check_val("period",   pm_if.period_out,    m_period);
        check_val("freq_err", pm_if.freq_err,      m_err);
        check_val("sign",     pm_if.freq_err_sign, m_sign);
        check_val("overflow", pm_if.overflow,      m_ovf);
        check_val("locked",   pm_if.locked,        m_locked);
    endtask

    task automatic model_reset();
        pend.delete();
        sig_prev  = 1'b0;
        en_ok     = 1'b0;
        have_prev = 1'b0;
        streak    = 0;
        m_period  = 0;
        m_err     = 0;
        m_sign    = 1'b0;
        m_ovf     = 1'b0;
        m_valid   = 1'b0;
        m_locked  = 1'b0;
    endtask

    // One rising clk edge: a rise sampled now is seen two edges later; the
    // interval between consecutive seen rises is the period.
    task automatic model_edge();
        bit rise;
        bit is_edge;
        int d;
        int e;
        cyc++;
        rise     = pm_if.sig_in && !sig_prev;
        sig_prev = pm_if.sig_in;
        if (rise) pend.push_back(cyc + 2);
        is_edge = 1'b0;
        if (pend.size() > 0 && pend[0] == cyc) begin
            is_edge = 1'b1;
            void'(pend.pop_front());
        end
        m_valid = 1'b0;
        if (!pm_if.enable) begin
            en_ok     = 1'b0;
            have_prev = 1'b0;
            streak    = 0;
            m_locked  = 1'b0;
        end else if (!en_ok) begin
            en_ok = 1'b1;
        end else if (is_edge) begin
            if (!have_prev) begin
                have_prev = 1'b1;
                prev_p    = cyc;
            end else begin
                d        = cyc - prev_p;
                prev_p   = cyc;
                m_ovf    = (d > MAXV);
                m_period = m_ovf ? MAXV : d;
                e        = int'(pm_if.expected);
                m_sign   = (m_period > e);
                m_err    = (m_period > e) ? (m_period - e) : (e - m_period);
                m_valid  = 1'b1;
                if (!m_ovf && m_err <= LOCK_TOL) begin
                    streak   = (streak + 1 > LOCK_COUNT) ? LOCK_COUNT : streak + 1;
                    m_locked = (streak == LOCK_COUNT);
                end else begin
                    streak   = 0;
                    m_locked = 1'b0;
                end
            end
        end
    endtask

    task automatic gen_sig();
        pm_if.sig_in = (phase < cur_p / 2);
        phase++;
        if (phase >= cur_p) begin
            phase = 0;
            cur_p = next_p;
        end
    endtask

    task automatic tick();
        gen_sig();
        @(posedge clk);
        if (reset) model_edge();
        @(negedge clk);
        check_all();
        if (pm_if.period_valid) begin
            nvalid++;
            if (nvalid == 3) lock_at3 = pm_if.locked;
            if (nvalid == 4) lock_at4 = pm_if.locked;
        end
    endtask

    task automatic run(input int p, input int n);
        int ticks;
        next_p = p;
        ticks  = cur_p + p * n;
        repeat (ticks) tick();
    endtask

    // Asynchronous reset pulse with sig_in parked low; outputs must clear at once.
    task automatic do_reset();
        reset        = 1'b0;
        pm_if.sig_in = 1'b0;
        phase        = cur_p / 2;
        #1;
        model_reset();
        check_val("rst_period", pm_if.period_out, 0);
        check_val("rst_locked", pm_if.locked, 0);
        check_all();
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_all();
        end
        reset = 1'b1;
    endtask

    initial begin
        bit found;
        reset          = 1'b0;
        pm_if.enable   = 1'b0;
        pm_if.sig_in   = 1'b0;
        pm_if.expected = 5'd8;
        do_reset();

        // period 8, expected 8: lock on the 4th valid
        pm_if.enable = 1'b1;
        nvalid = 0;
        run(8, 7);
        check_val("t1_period", pm_if.period_out, 8);
        check_val("t1_err", pm_if.freq_err, 0);
        check_val("t1_sign", pm_if.freq_err_sign, 0);
        check_val("t1_lock_at3", lock_at3, 0);
        check_val("t1_lock_at4", lock_at4, 1);

        // period 9 stays in tolerance, period 10 drops lock
        run(9, 4);
        check_val("t2_p9_period", pm_if.period_out, 9);
        check_val("t2_p9_err", pm_if.freq_err, 1);
        check_val("t2_p9_locked", pm_if.locked, 1);
        run(10, 4);
        check_val("t2_p10_period", pm_if.period_out, 10);
        check_val("t2_p10_err", pm_if.freq_err, 2);
        check_val("t2_p10_sign", pm_if.freq_err_sign, 1);
        check_val("t2_p10_locked", pm_if.locked, 0);

        // relock, then saturate on a too-slow clock and recover
        run(8, 7);
        check_val("t3_relock", pm_if.locked, 1);
        run(40, 3);
        check_val("t3_sat_period", pm_if.period_out, 31);
        check_val("t3_sat_ovf", pm_if.overflow, 1);
        check_val("t3_sat_err", pm_if.freq_err, 23);
        check_val("t3_sat_locked", pm_if.locked, 0);
        run(8, 3);
        check_val("t3_rec_ovf", pm_if.overflow, 0);
        check_val("t3_rec_period", pm_if.period_out, 8);

        // enable dropped mid-interval
        run(8, 6);
        repeat (3) tick();
        pm_if.enable = 1'b0;
        tick();
        check_val("t4_dis_locked", pm_if.locked, 0);
        check_val("t4_dis_hold", pm_if.period_out, 8);
        repeat (6) tick();
        pm_if.enable = 1'b1;
        nvalid = 0;
        run(8, 3);
        check_val("t4_reen_valid", int'(nvalid > 0), 1);

        // reset pulse mid-interval
        repeat (5) tick();
        do_reset();
        nvalid = 0;
        run(8, 3);
        check_val("t5_post_rst_valid", int'(nvalid > 0), 1);

        // enable dropped on the exact cycle an edge reaches the meter
        run(8, 3);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (pend.size() > 0 && pend[0] == cyc + 1) begin
                found = 1'b1;
                pm_if.enable = 1'b0;
                tick();
                check_val("t6_no_valid", pm_if.period_valid, 0);
            end else begin
                tick();
            end
        end
        check_val("t6_edge_found", found, 1);
        repeat (2) tick();
        pm_if.enable = 1'b1;
        run(8, 3);

        // randomized segments
        for (int s = 0; s < 16; s++) begin
            int p;
            int e;
            int ticks;
            if ($urandom_range(0, 3) == 0) p = $urandom_range(33, 45);
            else p = $urandom_range(2, 30);
            e = p + int'($urandom_range(0, 4)) - 2;
            if (e < 0) e = 0;
            if (e > MAXV) e = MAXV;
            pm_if.expected = WIDTH'(e);
            next_p = p;
            ticks  = cur_p + p * int'($urandom_range(3, 6));
            for (int t = 0; t < ticks; t++) begin
                if (t == ticks / 2 && $urandom_range(0, 3) == 0)
                    pm_if.expected = WIDTH'($urandom_range(0, MAXV));
                if ($urandom_range(0, 199) == 0) pm_if.enable = 1'b0;
                else if (!pm_if.enable && $urandom_range(0, 3) == 0) pm_if.enable = 1'b1;
                tick();
            end
            pm_if.enable = 1'b1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
